// File: rtl/cnt_pwm_gen_if.sv
// Duty-cycle update handshake between a duty source and cnt_pwm_gen.
// The source offers duty_in/duty_valid; the generator answers with duty_ready.
interface cnt_pwm_gen_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH:0] duty_in;
  logic           duty_valid;
  logic           duty_ready;

  modport master (output duty_in, output duty_valid, input  duty_ready);
  modport slave  (input  duty_in, input  duty_valid, output duty_ready);
endinterface

// File: rtl/cnt_pwm_gen.sv
// PWM generator slaved to an external free-running up counter. It locks on a
// counter wrap, tracks the count sequence, and swaps duty values on wrap boundaries.
module cnt_pwm_gen #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             en,
  cnt_pwm_gen_if.slave     duty,
  output logic             pwm_out,
  output logic             period_pulse,
  output logic             sync_err,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ARM  = 2'b01,
    RUN  = 2'b10
  } st_t;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  st_t            st, st_nxt;
  logic [WIDTH-1:0] cnt_prev, cnt_succ;
  logic [WIDTH:0]   duty_act, duty_pend, duty_act_nxt;
  logic             pend_vld;
  logic             wrap, inseq, xfer, apply;

  assign cnt_succ = cnt_prev + WIDTH'(1);
  assign wrap     = (cnt_prev == CNT_MAX) && (cnt_in == '0);
  assign inseq    = (cnt_in == cnt_succ);

  assign duty.duty_ready = ~pend_vld;
  assign xfer  = duty.duty_valid && ~pend_vld;
  // pend_vld is only set after the capture edge, so a wrap on the capture
  // edge itself never applies the new value.
  assign apply = pend_vld && ((st == IDLE) || wrap);
  assign duty_act_nxt = apply ? duty_pend : duty_act;

  always_comb begin
    st_nxt = st;
    if (!en) begin
      st_nxt = IDLE;
    end else begin
      case (st)
        IDLE:    st_nxt = ARM;
        ARM:     if (wrap)   st_nxt = RUN;
        RUN:     if (!inseq) st_nxt = ARM;
        default: st_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st           <= IDLE;
      cnt_prev     <= '0;
      duty_act     <= '0;
      duty_pend    <= '0;
      pend_vld     <= 1'b0;
      pwm_out      <= 1'b0;
      period_pulse <= 1'b0;
      sync_err     <= 1'b0;
    end else begin
      st       <= st_nxt;
      cnt_prev <= cnt_in;

      if (apply) begin
        duty_act <= duty_pend;
        pend_vld <= 1'b0;
      end else if (xfer) begin
        duty_pend <= duty.duty_in;
        pend_vld  <= 1'b1;
      end

      // Outputs follow the state being entered so the wrap edge already
      // produces the first high sample of the new period.
      pwm_out      <= (st_nxt == RUN) && ({1'b0, cnt_in} < duty_act_nxt);
      period_pulse <= (st_nxt == RUN) && wrap;

      if (!en)
        sync_err <= 1'b0;
      else if ((st == RUN) && !inseq)
        sync_err <= 1'b1;
    end
  end

  assign state = st;

endmodule

// File: tb/tb_cnt_pwm_gen.sv
// Self-checking bench for cnt_pwm_gen: duty table plus hand-written corner sequences.
module tb_cnt_pwm_gen;

  logic       clk, rst, en;
  logic [3:0] cnt_in;
  logic       pwm_out, period_pulse, sync_err;
  logic [1:0] state;

  cnt_pwm_gen_if #(.WIDTH(4)) dif();

  cnt_pwm_gen #(.WIDTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .cnt_in       (cnt_in),
    .en           (en),
    .duty         (dif),
    .pwm_out      (pwm_out),
    .period_pulse (period_pulse),
    .sync_err     (sync_err),
    .state        (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int duty;
    int exp_high;
  } vec_t;

  typedef struct {
    logic       pwm;
    logic       pp;
    logic       rdy;
    logic [1:0] st;
  } exp_t;

  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];

  // Reference view of the duty path: active value, pending value, ready flag.
  int   cur = 0;
  int   pend = 0;
  bit   pend_have = 0;
  bit   exp_rdy = 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick(input int c);
    cnt_in = 4'(c);
    @(posedge clk);
    #1;
  endtask

  task automatic arm_seq(input int from, input int to);
    for (int c = from; c <= to; c++) begin
      tick(c);
      chk("arm_state", state, 1);
      chk("arm_pwm", pwm_out, 0);
      chk("arm_pulse", period_pulse, 0);
    end
  endtask

  // One full counter period 0..15 in RUN; optionally offers a duty at offer_at.
  task automatic run_period(input int offer_at, input int nd, output int highs);
    exp_t e, g;
    int   pulses;
    highs  = 0;
    pulses = 0;
    for (int c = 0; c < 16; c++) begin
      if (c == 0 && pend_have) begin
        cur = pend;
        pend_have = 0;
        exp_rdy = 1;
      end
      if (c == offer_at) begin
        dif.duty_valid = 1'b1;
        dif.duty_in    = 5'(nd);
        pend = nd;
        pend_have = 1;
        exp_rdy = 0;
      end
      e.pwm = (c < cur);
      e.pp  = (c == 0);
      e.rdy = exp_rdy;
      e.st  = 2'b10;
      exp_q.push_back(e);
      tick(c);
      dif.duty_valid = 1'b0;
      g = exp_q.pop_front();
      chk("run_pwm", pwm_out, g.pwm);
      chk("run_pulse", period_pulse, g.pp);
      chk("run_ready", dif.duty_ready, g.rdy);
      chk("run_state", state, g.st);
      highs  += int'(pwm_out);
      pulses += int'(period_pulse);
    end
    chk("pulses_per_period", pulses, 1);
  endtask

  initial begin
    vec_t vecs[7];
    int   h;
    vecs[0] = '{5, 5};
    vecs[1] = '{12, 12};
    vecs[2] = '{0, 0};
    vecs[3] = '{16, 16};
    vecs[4] = '{20, 16};
    vecs[5] = '{1, 1};
    vecs[6] = '{15, 15};

    rst = 1'b0; en = 1'b0; cnt_in = '0;
    dif.duty_valid = 1'b0; dif.duty_in = '0;
    #1 rst = 1'b1;
    #1;
    chk("rst_state", state, 0);
    chk("rst_pwm", pwm_out, 0);
    chk("rst_pulse", period_pulse, 0);
    chk("rst_sync", sync_err, 0);
    chk("rst_ready", dif.duty_ready, 1);
    #1 rst = 1'b0;

    // Load duty 5 while idle: captured, then applied on the following edge.
    dif.duty_valid = 1'b1; dif.duty_in = 5'd5;
    tick(0);
    dif.duty_valid = 1'b0;
    chk("idle_capture_ready", dif.duty_ready, 0);
    chk("idle_state", state, 0);
    tick(1);
    chk("idle_apply_ready", dif.duty_ready, 1);
    cur = 5;

    en = 1'b1;
    arm_seq(2, 15);
    run_period(-1, 0, h);
    chk("first_run_high", h, 5);

    // Duty table: offer mid-period, old duty holds, new duty from next wrap.
    foreach (vecs[i]) begin
      run_period(7, vecs[i].duty, h);
      run_period(-1, 0, h);
      chk("table_high", h, vecs[i].exp_high);
    end

    // Sequence break 6 -> 9 drops to ARM and sets the sticky error.
    for (int c = 0; c <= 6; c++) begin
      tick(c);
      chk("pre_break_state", state, 2);
    end
    tick(9);
    chk("break_state", state, 1);
    chk("break_sync", sync_err, 1);
    chk("break_pwm", pwm_out, 0);
    arm_seq(10, 15);
    run_period(-1, 0, h);
    chk("resume_sync_sticky", sync_err, 1);
    chk("resume_high", h, 15);

    // One-cycle enable drop clears the error and re-arms with duty retained.
    en = 1'b0;
    tick(0);
    chk("endrop_state", state, 0);
    chk("endrop_sync", sync_err, 0);
    chk("endrop_pwm", pwm_out, 0);
    en = 1'b1;
    arm_seq(1, 15);
    run_period(-1, 0, h);
    chk("retained_high", h, 15);

    // Break on the same edge as enable falling must not flag an error.
    en = 1'b0;
    tick(9);
    chk("break_en_low_state", state, 0);
    chk("break_en_low_sync", sync_err, 0);
    en = 1'b1;
    arm_seq(10, 15);

    // Asynchronous reset mid-period with a duty pending.
    tick(0);
    chk("pre_rst_state", state, 2);
    dif.duty_valid = 1'b1; dif.duty_in = 5'd2;
    tick(1);
    dif.duty_valid = 1'b0;
    tick(2);
    tick(3);
    chk("pre_rst_pwm", pwm_out, 1);
    chk("pre_rst_ready", dif.duty_ready, 0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_state", state, 0);
    chk("async_rst_pwm", pwm_out, 0);
    chk("async_rst_pulse", period_pulse, 0);
    chk("async_rst_sync", sync_err, 0);
    chk("async_rst_ready", dif.duty_ready, 1);
    rst = 1'b0;
    cur = 0; pend_have = 0; exp_rdy = 1;
    arm_seq(4, 5);
    dif.duty_valid = 1'b1; dif.duty_in = 5'd7;
    tick(6);
    dif.duty_valid = 1'b0;
    pend = 7; pend_have = 1; exp_rdy = 0;
    chk("post_rst_arm_state", state, 1);
    chk("post_rst_capture_ready", dif.duty_ready, 0);
    arm_seq(7, 15);
    run_period(-1, 0, h);
    chk("post_rst_high", h, 7);

    // Transfer on the wrap edge itself waits for the following wrap.
    run_period(0, 3, h);
    chk("wrap_xfer_old_high", h, 7);
    run_period(-1, 0, h);
    chk("wrap_xfer_new_high", h, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cnt_pwm_gen.md
CNT_PWM_GEN -- requirements
Module: cnt_pwm_gen

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 Parameter WIDTH, default 4, SHALL set the count width (matches the 4-bit synchronous up counter upstream).
REQ-003 Port clk  input  1  sole clock, rising edge active.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port cnt_in  input  WIDTH  count value from the upstream up counter, stable at each rising clk.
REQ-006 Port en  input  1  run enable; low forces IDLE.
REQ-007 Port duty_in  input  WIDTH+1  requested high-time in counts, range 0..2^WIDTH.
REQ-008 Port duty_valid  input  1  duty_in is offered.
REQ-009 Port duty_ready  output  1  high when no duty update is pending.
REQ-010 Port pwm_out  output  1  registered PWM output.
REQ-011 Port period_pulse  output  1  one-cycle pulse per detected counter wrap while in RUN.
REQ-012 Port sync_err  output  1  sticky flag for a count-sequence break.
REQ-013 Port state  output  2  FSM state: 00 IDLE, 01 ARM, 10 RUN.

Function
REQ-014 Every rising clk SHALL register cnt_in into cnt_prev.
REQ-015 Wrap SHALL be defined as cnt_prev == 2^WIDTH-1 and cnt_in == 0.
REQ-016 In-sequence SHALL be defined as cnt_in == (cnt_prev+1) mod 2^WIDTH.
REQ-017 FSM IDLE -> ARM SHALL occur when en == 1.
REQ-018 FSM ARM -> RUN SHALL occur on a wrap.
REQ-019 FSM RUN -> ARM SHALL occur on any out-of-sequence sample; the same edge sets sync_err.
REQ-020 Any state -> IDLE SHALL occur when en == 0; this has priority over all other transitions.
REQ-021 Duty handshake: transfer SHALL occur when duty_valid && duty_ready; duty_in is captured into duty_pend and duty_ready drops on the next edge.
REQ-022 duty_pend SHALL be copied to duty_act on the first wrap strictly after capture, which reasserts duty_ready; in IDLE, duty_pend applies on the next edge.
REQ-023 Transfer and wrap on the same edge: the new value SHALL wait for the following wrap; duty_act keeps its old value for the current period.
REQ-024 In RUN: pwm_out SHALL equal (cnt_in < duty_act), registered, so pwm_out lags cnt_in by exactly one clk.
REQ-025 Comparison SHALL be WIDTH+1 bits unsigned: duty_act 0 gives constant low; duty_act >= 2^WIDTH gives constant high.
REQ-026 In IDLE and ARM: pwm_out SHALL be 0.
REQ-027 period_pulse SHALL be 1 for exactly one clk, registered, on each wrap seen in RUN; the ARM->RUN wrap also pulses.
REQ-028 sync_err SHALL remain set until en == 0 or rst.
REQ-029 A sequence break on the same edge as en falling SHALL not set sync_err.

Reset
REQ-030 rst high SHALL immediately and asynchronously force: state=IDLE, pwm_out=0, period_pulse=0, sync_err=0, duty_ready=1, duty_act=0, duty_pend=0, cnt_prev=0.
REQ-031 Reset mid-period SHALL discard any pending duty.
REQ-032 After rst deasserts, the block SHALL need a full ARM wrap before pwm_out can go high.

Verification
REQ-033 en=1, duty=5 loaded in IDLE, counter free-running 0..15 -> RUN after first 15->0; pwm_out high for 5 clks then low for 11; period_pulse every 16 clks.
REQ-034 In RUN with duty_act=5, offer duty 12 at cnt_in=7 -> duty_ready low; pwm stays 5/16 for the rest of this period; 12/16 from the next wrap; duty_ready high after that wrap.
REQ-035 duty=0 -> pwm_out constant 0; duty=16 -> pwm_out constant 1; duty=20 -> constant 1; period_pulse unaffected.
REQ-036 In RUN, force cnt_in 6->9 -> sync_err=1, state=ARM, pwm_out=0 next clk; RUN resumes after next wrap with sync_err still 1; en low clears it.
REQ-037 Assert rst at cnt_in=3 with pwm_out=1 and a duty pending -> all outputs reset with no clk edge; after release, a new duty applies only after the ARM wrap.
REQ-038 Drop en for one clk mid-RUN -> state IDLE, pwm_out 0; re-arm and resume on the next wrap with duty_act retained.
